// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
//   Shared widths for the IF->ID fetch queue. These mirror the processor-wide
//   address, instruction and queue-depth defines so the queue can be elaborated
//   stand-alone.
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam int unsigned ADDRESS_LEN       = 32;
    localparam int unsigned INSTRUCTION_LEN   = 32;
    localparam int unsigned FETCH_QUEUE_DEPTH = 4;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_ram.sv
// -----------------------------------------------------------------------------
// fetch_queue_ram
//   DEPTH x DATA_W register file backing the fetch queue. One synchronous write
//   port and one asynchronous read port. The data array has no reset.
// Ports
//   i_clk    clock; the write happens on posedge
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data (combinational from i_raddr)
// -----------------------------------------------------------------------------
module fetch_queue_ram #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 64,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : fetch_queue_ram

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Decoupling buffer between IF and ID. Captures {PC, instruction} pairs from
//   IF and presents them to ID in FIFO order with a valid/ready handshake.
//   Freezes IF when full and discards everything on a taken branch (flush).
// Ports
//   i_clk             clock
//   i_rst_n           asynchronous active-low reset
//   i_fetch_valid     IF presents a valid fetch this cycle
//   i_if_pc           PC of the fetch
//   i_if_instruction  instruction word of the fetch
//   i_flush           taken branch from EXE; empties the queue
//   o_freeze          back-pressure to IF (hold PC)
//   o_id_valid        head entry valid for ID
//   i_id_ready        ID accepts the head entry
//   o_id_pc           head entry PC (0 when empty)
//   o_id_instruction  head entry instruction (0 when empty)
//   o_count           current occupancy
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = FETCH_QUEUE_DEPTH,
    parameter int unsigned ADDR_W  = ADDRESS_LEN,
    parameter int unsigned INSTR_W = INSTRUCTION_LEN,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_fetch_valid,
    input  logic [ADDR_W-1:0]  i_if_pc,
    input  logic [INSTR_W-1:0] i_if_instruction,
    input  logic               i_flush,
    output logic               o_freeze,
    output logic               o_id_valid,
    input  logic               i_id_ready,
    output logic [ADDR_W-1:0]  o_id_pc,
    output logic [INSTR_W-1:0] o_id_instruction,
    output logic [CNT_W-1:0]   o_count
);

    localparam int unsigned DATA_W = ADDR_W + INSTR_W;

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_rdata;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // A fetch arriving while full is dropped even if ID pops in the same cycle;
    // IF is frozen and will present it again.
    assign w_push = i_fetch_valid & ~w_full & ~i_flush;
    assign w_pop  = o_id_valid & i_id_ready & ~i_flush;

    fetch_queue_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata ({i_if_pc, i_if_instruction}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // IF must be free to load the branch target during a flush, even when full.
    assign o_freeze   = w_full & ~i_flush;
    assign o_id_valid = ~w_empty;
    assign o_count    = r_count;

    always_comb begin
        o_id_pc          = '0;
        o_id_instruction = '0;
        if (!w_empty) begin
            o_id_pc          = w_rdata[DATA_W-1 -: ADDR_W];
            o_id_instruction = w_rdata[INSTR_W-1:0];
        end
    end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        flush;
    logic        freeze;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        fl;
        logic        rdy;
        logic        e_frz;   // freeze before the edge
        logic        e_val;   // id_valid after the edge
        logic [2:0]  e_cnt;   // count after the edge
        logic [31:0] e_pc;    // head PC after the edge (0 when empty)
    } vec_t;

    vec_t vecs[$];

    fetch_queue dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_fetch_valid    (fetch_valid),
        .i_if_pc          (if_pc),
        .i_if_instruction (if_instruction),
        .i_flush          (flush),
        .o_freeze         (freeze),
        .o_id_valid       (id_valid),
        .i_id_ready       (id_ready),
        .o_id_pc          (id_pc),
        .o_id_instruction (id_instruction),
        .o_count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word tied to its PC so ordering errors show in both fields.
    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic fv, input logic [31:0] pc, input logic fl, input logic rdy,
                       input logic e_frz, input logic e_val, input logic [2:0] e_cnt,
                       input logic [31:0] e_pc);
        vec_t v;
        v.fv = fv; v.pc = pc; v.fl = fl; v.rdy = rdy;
        v.e_frz = e_frz; v.e_val = e_val; v.e_cnt = e_cnt; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    // Called 1 time unit after a posedge: drive, check freeze, clock, check state.
    task automatic apply(input vec_t v, input int idx);
        logic [31:0] e_ins;
        fetch_valid    = v.fv;
        if_pc          = v.pc;
        if_instruction = ins_of(v.pc);
        flush          = v.fl;
        id_ready       = v.rdy;
        #1;
        chk($sformatf("v%0d freeze", idx), {31'd0, freeze}, {31'd0, v.e_frz});
        @(posedge clk);
        #1;
        e_ins = v.e_val ? ins_of(v.e_pc) : 32'd0;
        chk($sformatf("v%0d id_valid", idx), {31'd0, id_valid}, {31'd0, v.e_val});
        chk($sformatf("v%0d count", idx), {29'd0, count}, {29'd0, v.e_cnt});
        chk($sformatf("v%0d id_pc", idx), id_pc, v.e_pc);
        chk($sformatf("v%0d id_instr", idx), id_instruction, e_ins);
    endtask

    initial begin
        // Fill: 4 pushes, dropped 5th (also with a simultaneous pop), drain in order.
        add(1, 32'd0,  0, 0, 0, 1, 3'd1, 32'd0);
        add(1, 32'd4,  0, 0, 0, 1, 3'd2, 32'd0);
        add(1, 32'd8,  0, 0, 0, 1, 3'd3, 32'd0);
        add(1, 32'd12, 0, 0, 0, 1, 3'd4, 32'd0);
        add(1, 32'd16, 0, 0, 1, 1, 3'd4, 32'd0);
        add(1, 32'd16, 0, 1, 1, 1, 3'd3, 32'd4);
        add(0, 32'd0,  0, 1, 0, 1, 3'd2, 32'd8);
        add(0, 32'd0,  0, 1, 0, 1, 3'd1, 32'd12);
        add(0, 32'd0,  0, 1, 0, 0, 3'd0, 32'd0);
        // Streaming: one prefill, then 10 cycles of push+pop.
        add(1, 32'h200, 0, 0, 0, 1, 3'd1, 32'h200);
        for (int k = 0; k < 10; k++) begin
            add(1, 32'h204 + 32'(4 * k), 0, 1, 0, 1, 3'd1, 32'h204 + 32'(4 * k));
        end
        add(0, 32'd0, 0, 1, 0, 0, 3'd0, 32'd0);
        // Wrap: 3 pushes then 3 pops, three rounds.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                add(1, 32'h1000 + 32'(16 * r) + 32'(4 * k), 0, 0, 0, 1, 3'(k + 1),
                    32'h1000 + 32'(16 * r));
            end
            for (int k = 0; k < 3; k++) begin
                add(0, 32'd0, 0, 1, 0, (k < 2), 3'(2 - k),
                    (k < 2) ? 32'h1000 + 32'(16 * r) + 32'(4 * (k + 1)) : 32'd0);
            end
        end
        // Flush when full: freeze masked in the flush cycle, wrong-path fetch discarded.
        add(1, 32'h300, 0, 0, 0, 1, 3'd1, 32'h300);
        add(1, 32'h304, 0, 0, 0, 1, 3'd2, 32'h300);
        add(1, 32'h308, 0, 0, 0, 1, 3'd3, 32'h300);
        add(1, 32'h30C, 0, 0, 0, 1, 3'd4, 32'h300);
        add(1, 32'h999, 1, 1, 0, 0, 3'd0, 32'd0);
        add(1, 32'h100, 0, 0, 0, 1, 3'd1, 32'h100);
        add(1, 32'h104, 0, 0, 0, 1, 3'd2, 32'h100);
        add(0, 32'd0,   0, 1, 0, 1, 3'd1, 32'h104);
        add(0, 32'd0,   0, 1, 0, 0, 3'd0, 32'd0);

        // Reset held with a fetch presented: nothing is captured.
        rst_n          = 1'b0;
        fetch_valid    = 1'b1;
        if_pc          = 32'h40;
        if_instruction = ins_of(32'h40);
        flush          = 1'b0;
        id_ready       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst freeze", {31'd0, freeze}, 32'd0);
        chk("rst count", {29'd0, count}, 32'd0);
        chk("rst id_pc", id_pc, 32'd0);
        chk("rst id_instr", id_instruction, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i], i);
        end

        // Async reset between edges with two entries queued.
        begin
            vec_t v;
            v.fv = 1; v.pc = 32'h400; v.fl = 0; v.rdy = 0;
            v.e_frz = 0; v.e_val = 1; v.e_cnt = 3'd1; v.e_pc = 32'h400;
            apply(v, 900);
            v.pc = 32'h404; v.e_cnt = 3'd2;
            apply(v, 901);
            fetch_valid = 1'b0;
            #2;
            rst_n = 1'b0;
            #1;
            chk("async count", {29'd0, count}, 32'd0);
            chk("async id_valid", {31'd0, id_valid}, 32'd0);
            chk("async id_pc", id_pc, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            v.pc = 32'h500; v.e_cnt = 3'd1; v.e_pc = 32'h500;
            apply(v, 902);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_queue
